// File: rtl/counter_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_arbiter_if
//  Purpose  : Request/grant, counter-control and completion-report bundle
//             between two requesters, the counter_arbiter and an external
//             4-bit mode counter.
//  Revision : 1.0 - initial release
// ============================================================================
interface counter_arbiter_if;
  // Requester side
  logic [1:0] req;         // request from requester i
  logic [3:0] mode_in;     // {mode1, mode0}
  logic [7:0] d_in;        // {d1, d0}
  logic [7:0] len_in;      // {len1, len0}
  logic [1:0] gnt;         // one-hot grant, LOAD cycle only

  // Counter control and feedback
  logic       cnt_enable;
  logic [1:0] cnt_mode;
  logic [3:0] cnt_d;
  logic [3:0] cnt_q;
  logic       cnt_rco;

  // Completion report
  logic       done;
  logic       done_id;
  logic [3:0] result_q;
  logic [3:0] rco_count;

  // The arbiter itself
  modport slave (
    input  req, mode_in, d_in, len_in, cnt_q, cnt_rco,
    output gnt, cnt_enable, cnt_mode, cnt_d, done, done_id, result_q, rco_count
  );

  // Requesters plus the counter, seen from the outside
  modport master (
    output req, mode_in, d_in, len_in, cnt_q, cnt_rco,
    input  gnt, cnt_enable, cnt_mode, cnt_d, done, done_id, result_q, rco_count
  );
endinterface
`default_nettype wire

// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : counter_arbiter
//  Purpose  : Round-robin arbiter for two requesters sharing one external
//             4-bit mode counter. The winner's mode/start/length are latched,
//             the counter is loaded, run for len steps, and the final count
//             is reported with the winner's index.
//  Option   : define COUNTER_ARBITER_RCO_CNT_EN to build the ripple-carry
//             event counter behind rco_count; otherwise rco_count is tied 0.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_arbiter #(
  parameter logic [1:0] MODE_LOAD = 2'b11
) (
  input  logic             clk,
  input  logic             reset,
  counter_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;        // index of the most recently granted requester
  logic       id_q, id_d;            // index of the requester being served
  logic [1:0] mode_q, mode_d;        // latched run mode
  logic [3:0] d_q, d_d;              // latched start value
  logic [3:0] len_q, len_d;          // latched step count
  logic [3:0] step_q, step_d;        // RUN cycles completed so far
  logic       done_id_q, done_id_d;
  logic [3:0] res_q, res_d;

  logic       pick;
  logic [1:0] gnt_w;
  logic       en_w;
  logic [1:0] mode_w;
  logic [3:0] cd_w;
  logic       done_w;

  // Round-robin choice: on a tie the requester not served last wins
  always_comb begin
    pick = 1'b0;
    if (bus.req == 2'b11) begin
      pick = ~last_q;
    end else begin
      pick = bus.req[1];
    end
  end

  // Next-state, job latching, step counting and result capture
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    mode_d    = mode_q;
    d_d       = d_q;
    len_d     = len_q;
    step_d    = step_q;
    done_id_d = done_id_q;
    res_d     = res_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = LOAD;
          id_d    = pick;
          last_d  = pick;
          mode_d  = pick ? bus.mode_in[3:2] : bus.mode_in[1:0];
          d_d     = pick ? bus.d_in[7:4]    : bus.d_in[3:0];
          len_d   = pick ? bus.len_in[7:4]  : bus.len_in[3:0];
        end
      end
      LOAD: begin
        step_d  = 4'd0;
        state_d = (len_q != 4'd0) ? RUN : DONE;
      end
      RUN: begin
        step_d = step_q + 4'd1;
        // step_q counts completed RUN cycles, so this is the len-th one
        if ((step_q + 4'd1) == len_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        done_id_d = id_q;
        res_d     = bus.cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and job registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;   // requester 0 wins the first tie
      id_q      <= 1'b0;
      mode_q    <= 2'd0;
      d_q       <= 4'd0;
      len_q     <= 4'd0;
      step_q    <= 4'd0;
      done_id_q <= 1'b0;
      res_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      mode_q    <= mode_d;
      d_q       <= d_d;
      len_q     <= len_d;
      step_q    <= step_d;
      done_id_q <= done_id_d;
      res_q     <= res_d;
    end
  end

  // Counter controls and grant decoded from the current state
  always_comb begin
    gnt_w  = 2'b00;
    en_w   = 1'b0;
    mode_w = 2'd0;
    cd_w   = 4'd0;
    done_w = 1'b0;
    case (state_q)
      LOAD: begin
        gnt_w  = id_q ? 2'b10 : 2'b01;
        en_w   = 1'b1;
        mode_w = MODE_LOAD;
        cd_w   = d_q;
      end
      RUN: begin
        en_w   = 1'b1;
        mode_w = mode_q;   // a latched load code simply reloads d each step
        cd_w   = d_q;
      end
      DONE: begin
        done_w = 1'b1;     // enable low clears the counter
      end
      default: ;
    endcase
  end

  assign bus.gnt        = gnt_w;
  assign bus.cnt_enable = en_w;
  assign bus.cnt_mode   = mode_w;
  assign bus.cnt_d      = cd_w;
  assign bus.done       = done_w;
  assign bus.done_id    = done_id_q;
  assign bus.result_q   = res_q;

`ifdef COUNTER_ARBITER_RCO_CNT_EN
  // rco_acc gathers events during the job; rco_cnt is the held report
  logic [3:0] rco_acc_q, rco_acc_d;
  logic [3:0] rco_cnt_q, rco_cnt_d;

  // Count carry events on RUN cycles 2..len and the DONE cycle, saturating.
  // RUN cycle 1 shows the carry of the load edge, which is never a step.
  always_comb begin
    rco_acc_d = rco_acc_q;
    rco_cnt_d = rco_cnt_q;
    case (state_q)
      LOAD: rco_acc_d = 4'd0;
      RUN: begin
        if ((step_q != 4'd0) && bus.cnt_rco && (rco_acc_q != 4'hF)) begin
          rco_acc_d = rco_acc_q + 4'd1;
        end
      end
      DONE: begin
        rco_cnt_d = (bus.cnt_rco && (rco_acc_q != 4'hF)) ? rco_acc_q + 4'd1 : rco_acc_q;
      end
      default: ;
    endcase
  end

  // Carry event registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rco_acc_q <= 4'd0;
      rco_cnt_q <= 4'd0;
    end else begin
      rco_acc_q <= rco_acc_d;
      rco_cnt_q <= rco_cnt_d;
    end
  end

  assign bus.rco_count = rco_cnt_q;
`else
  logic unused_rco;
  assign unused_rco    = bus.cnt_rco;
  assign bus.rco_count = 4'd0;
`endif

endmodule
`default_nettype wire
